counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter_if.sv | 30 +++
 rtl/counter_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_counter_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// Request/operation bus between requesters and the counter arbiter,
// together with the counter-control and status outputs it drives.
interface counter_arbiter_if;
   logic [2:0]  REQ;
   logic [5:0]  OP;
   logic [11:0] LOAD_IN;
   logic        SAT_EN;
   logic [2:0]  ACK;
   logic        INCREASE;
   logic        DECREASE;
   logic        PARALLEL;
   logic        CNT_CLR;
   logic [3:0]  LOAD;
   logic [1:0]  GRANT_ID;
   logic        BUSY;
   logic [3:0]  Q_SHADOW;
   logic        SAT;

   modport slave (
      input  REQ, OP, LOAD_IN, SAT_EN,
      output ACK, INCREASE, DECREASE, PARALLEL, CNT_CLR, LOAD,
             GRANT_ID, BUSY, Q_SHADOW, SAT
   );

   modport master (
      output REQ, OP, LOAD_IN, SAT_EN,
      input  ACK, INCREASE, DECREASE, PARALLEL, CNT_CLR, LOAD,
             GRANT_ID, BUSY, Q_SHADOW, SAT
   );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter for three requesters sharing one 4-bit up/down/load
// counter; drives one-cycle control strobes and tracks the counter value.
module counter_arbiter (
   input logic              CLK,
   input logic              CLR,
   counter_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] NO_GRANT = 2'd3;

   state_t      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic        supp_q, supp_d;
   logic [3:0]  q_shadow_q, q_shadow_d;
   logic [2:0]  ack_q, ack_d;
   logic        inc_q, inc_d;
   logic        dec_q, dec_d;
   logic        par_q, par_d;
   logic        cnt_clr_q, cnt_clr_d;
   logic [3:0]  load_q, load_d;
   logic [1:0]  grant_id_q, grant_id_d;
   logic        busy_q, busy_d;
   logic        sat_q, sat_d;

   logic [1:0]  pick_s;
   logic [1:0]  op_sel_s;
   logic [3:0]  ld_sel_s;

   // Search starts one past the last winner and wraps 2 -> 0.
   function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [1:0] idx;
      logic [1:0] pick;
      logic       found;
      idx   = last;
      pick  = NO_GRANT;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [1:0] op_of(input logic [5:0] op, input logic [1:0] idx);
      case (idx)
         2'd0:    return op[1:0];
         2'd1:    return op[3:2];
         2'd2:    return op[5:4];
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] load_of(input logic [11:0] ld, input logic [1:0] idx);
      case (idx)
         2'd0:    return ld[3:0];
         2'd1:    return ld[7:4];
         2'd2:    return ld[11:8];
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [2:0] one_hot(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Next-state and next-output logic for the IDLE -> ISSUE -> DONE sequence.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      supp_d     = supp_q;
      q_shadow_d = q_shadow_q;
      grant_id_d = grant_id_q;
      busy_d     = busy_q;
      ack_d      = 3'b000;
      inc_d      = 1'b0;
      dec_d      = 1'b0;
      par_d      = 1'b0;
      cnt_clr_d  = 1'b0;
      load_d     = 4'd0;
      sat_d      = 1'b0;

      pick_s   = rr_pick(bus.REQ, last_q);
      op_sel_s = op_of(bus.OP, pick_s);
      ld_sel_s = load_of(bus.LOAD_IN, pick_s);

      case (state_q)
         S_IDLE: begin
            grant_id_d = NO_GRANT;
            busy_d     = 1'b0;
            supp_d     = 1'b0;
            if (bus.REQ != 3'b000) begin
               state_d    = S_ISSUE;
               grant_id_d = pick_s;
               last_d     = pick_s;
               busy_d     = 1'b1;
               // Strobes are decided here so they are registered for ISSUE.
               case (op_sel_s)
                  2'b00: begin
                     if (bus.SAT_EN && (q_shadow_q == 4'd15)) begin
                        supp_d = 1'b1;
                     end else begin
                        inc_d = 1'b1;
                     end
                  end
                  2'b01: begin
                     if (bus.SAT_EN && (q_shadow_q == 4'd0)) begin
                        supp_d = 1'b1;
                     end else begin
                        dec_d = 1'b1;
                     end
                  end
                  2'b10: begin
                     par_d  = 1'b1;
                     load_d = ld_sel_s;
                  end
                  2'b11: begin
                     cnt_clr_d = 1'b1;
                  end
                  default: begin
                     supp_d = 1'b0;
                  end
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_DONE;
            ack_d   = one_hot(grant_id_q);
            sat_d   = supp_q;
            if (inc_q) begin
               q_shadow_d = q_shadow_q + 4'd1;
            end else if (dec_q) begin
               q_shadow_d = q_shadow_q - 4'd1;
            end else if (par_q) begin
               q_shadow_d = load_q;
            end else if (cnt_clr_q) begin
               q_shadow_d = 4'd0;
            end else begin
               q_shadow_d = q_shadow_q;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            grant_id_d = NO_GRANT;
            busy_d     = 1'b0;
         end
         default: begin
            state_d    = S_IDLE;
            grant_id_d = NO_GRANT;
            busy_d     = 1'b0;
         end
      endcase
   end

   // State and output registers; CLR abandons any in-flight operation.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q    <= S_IDLE;
         last_q     <= 2'd2;
         supp_q     <= 1'b0;
         q_shadow_q <= 4'd0;
         ack_q      <= 3'b000;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         par_q      <= 1'b0;
         cnt_clr_q  <= 1'b0;
         load_q     <= 4'd0;
         grant_id_q <= NO_GRANT;
         busy_q     <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         supp_q     <= supp_d;
         q_shadow_q <= q_shadow_d;
         ack_q      <= ack_d;
         inc_q      <= inc_d;
         dec_q      <= dec_d;
         par_q      <= par_d;
         cnt_clr_q  <= cnt_clr_d;
         load_q     <= load_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
         sat_q      <= sat_d;
      end
   end

   assign bus.ACK      = ack_q;
   assign bus.INCREASE = inc_q;
   assign bus.DECREASE = dec_q;
   assign bus.PARALLEL = par_q;
   assign bus.CNT_CLR  = cnt_clr_q;
   assign bus.LOAD     = load_q;
   assign bus.GRANT_ID = grant_id_q;
   assign bus.BUSY     = busy_q;
   assign bus.Q_SHADOW = q_shadow_q;
   assign bus.SAT      = sat_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: directed operations push hand-computed
// expectations; a negedge monitor checks the ISSUE and DONE cycles against them.
module tb_counter_arbiter;

   localparam logic [3:0] ST_INC  = 4'b1000;
   localparam logic [3:0] ST_DEC  = 4'b0100;
   localparam logic [3:0] ST_PAR  = 4'b0010;
   localparam logic [3:0] ST_CLR  = 4'b0001;
   localparam logic [3:0] ST_NONE = 4'b0000;

   typedef struct {
      logic [1:0] grant;
      logic [3:0] strobe;
      logic [3:0] load;
      logic       sat;
      logic [3:0] q;
      int         issue;
      bit         abort;
   } exp_t;

   logic clk;
   logic clr;
   int   cyc;
   int   n_pass;
   int   n_total;
   logic prev_busy;
   exp_t sb[$];

   counter_arbiter_if bus_if();

   counter_arbiter dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [2:0] ack_of(input logic [1:0] g);
      logic [2:0] r;
      r = 3'b000;
      if (g < 2'd3) r[g] = 1'b1;
      return r;
   endfunction

   // Monitor: ISSUE is the first busy cycle, DONE is the ACK cycle.
   always @(negedge clk) begin
      prev_busy <= bus_if.BUSY;
      if (bus_if.BUSY === 1'b1 && prev_busy === 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_issue", 32'(bus_if.GRANT_ID), 32'd3);
         end else begin
            check("issue_cycle", 32'(cyc), 32'(sb[0].issue));
            check("issue_grant", 32'(bus_if.GRANT_ID), 32'(sb[0].grant));
            check("issue_strobes", 32'({bus_if.INCREASE, bus_if.DECREASE, bus_if.PARALLEL, bus_if.CNT_CLR}),
                  32'(sb[0].strobe));
            check("issue_load", 32'(bus_if.LOAD), 32'(sb[0].load));
            check("issue_ack", 32'(bus_if.ACK), 32'd0);
            if (sb[0].abort) void'(sb.pop_front());
         end
      end
      if (bus_if.ACK !== 3'b000 && bus_if.ACK !== 3'bxxx) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'(bus_if.ACK), 32'd0);
         end else begin
            check("done_ack", 32'(bus_if.ACK), 32'(ack_of(sb[0].grant)));
            check("done_cycle", 32'(cyc), 32'(sb[0].issue + 1));
            check("done_grant", 32'(bus_if.GRANT_ID), 32'(sb[0].grant));
            check("done_sat", 32'(bus_if.SAT), 32'(sb[0].sat));
            check("done_q", 32'(bus_if.Q_SHADOW), 32'(sb[0].q));
            check("done_strobes", 32'({bus_if.INCREASE, bus_if.DECREASE, bus_if.PARALLEL, bus_if.CNT_CLR}), 32'd0);
            void'(sb.pop_front());
         end
      end
      if (bus_if.BUSY === 1'b0) begin
         check("idle_outputs", 32'({bus_if.GRANT_ID, bus_if.ACK, bus_if.INCREASE, bus_if.DECREASE,
                                    bus_if.PARALLEL, bus_if.CNT_CLR, bus_if.SAT}), 32'({2'd3, 8'd0}));
      end
      if (sb.size() > 0 && cyc > sb[0].issue + 3) begin
         check("timeout_no_ack", 32'(cyc), 32'(sb[0].issue + 1));
         void'(sb.pop_front());
      end
   end

   task automatic push(input logic [1:0] g, input logic [3:0] st, input logic [3:0] ld,
                       input logic s, input logic [3:0] q, input int issue, input bit abort);
      exp_t e;
      e.grant = g; e.strobe = st; e.load = ld; e.sat = s; e.q = q; e.issue = issue; e.abort = abort;
      sb.push_back(e);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   // One operation; inputs are scrambled during ISSUE to prove they are ignored.
   task automatic do_op(input logic [2:0] req, input logic [5:0] op, input logic [11:0] ld,
                        input logic sat_en, input logic [1:0] g, input logic [3:0] st,
                        input logic [3:0] eld, input logic s, input logic [3:0] q, input bit abort);
      @(posedge clk); #1;
      bus_if.REQ = req; bus_if.OP = op; bus_if.LOAD_IN = ld; bus_if.SAT_EN = sat_en;
      push(g, st, eld, s, q, cyc + 1, abort);
      @(posedge clk); #1;
      if (abort) begin
         clr = 1'b1;
      end else begin
         bus_if.REQ = ~req; bus_if.OP = ~op; bus_if.LOAD_IN = ~ld;
      end
      @(posedge clk); #1;
      bus_if.REQ = 3'b000;
      if (abort) begin
         clr = 1'b0;
         check("abort_busy", 32'(bus_if.BUSY), 32'd0);
         check("abort_grant", 32'(bus_if.GRANT_ID), 32'd3);
         check("abort_q", 32'(bus_if.Q_SHADOW), 32'd0);
         check("abort_ack", 32'(bus_if.ACK), 32'd0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int c0;
      n_pass = 0; n_total = 0; cyc = 0; prev_busy = 1'b0;
      clr = 1'b1;
      bus_if.REQ = 3'b000; bus_if.OP = 6'd0; bus_if.LOAD_IN = 12'd0; bus_if.SAT_EN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", 32'(bus_if.ACK), 32'd0);
      check("rst_strobes_load", 32'({bus_if.INCREASE, bus_if.DECREASE, bus_if.PARALLEL, bus_if.CNT_CLR, bus_if.LOAD}), 32'd0);
      check("rst_busy_sat", 32'({bus_if.BUSY, bus_if.SAT}), 32'd0);
      check("rst_q", 32'(bus_if.Q_SHADOW), 32'd0);
      check("rst_grant", 32'(bus_if.GRANT_ID), 32'd3);
      clr = 1'b0;

      // Parallel load 0xA by requester 0.
      do_op(3'b001, 6'b000010, 12'h00A, 1'b0, 2'd0, ST_PAR, 4'hA, 1'b0, 4'hA, 1'b0);

      // All three held, increments, back-to-back round robin from reset.
      pulse_clr();
      @(posedge clk); #1;
      c0 = cyc;
      bus_if.REQ = 3'b111; bus_if.OP = 6'b000000; bus_if.LOAD_IN = 12'h000; bus_if.SAT_EN = 1'b0;
      push(2'd0, ST_INC, 4'd0, 1'b0, 4'd1, c0 + 1, 1'b0);
      push(2'd1, ST_INC, 4'd0, 1'b0, 4'd2, c0 + 4, 1'b0);
      push(2'd2, ST_INC, 4'd0, 1'b0, 4'd3, c0 + 7, 1'b0);
      push(2'd0, ST_INC, 4'd0, 1'b0, 4'd4, c0 + 10, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      bus_if.REQ = 3'b000;
      repeat (3) @(posedge clk);
      #1;

      // Saturation / wrap at 15.
      do_op(3'b010, 6'b001000, 12'h0F0, 1'b0, 2'd1, ST_PAR,  4'hF, 1'b0, 4'hF, 1'b0);
      do_op(3'b100, 6'b000000, 12'h000, 1'b1, 2'd2, ST_NONE, 4'h0, 1'b1, 4'hF, 1'b0);
      do_op(3'b001, 6'b000000, 12'h000, 1'b0, 2'd0, ST_INC,  4'h0, 1'b0, 4'h0, 1'b0);
      // Saturation / wrap at 0.
      do_op(3'b010, 6'b000100, 12'h000, 1'b1, 2'd1, ST_NONE, 4'h0, 1'b1, 4'h0, 1'b0);
      do_op(3'b100, 6'b010000, 12'h000, 1'b0, 2'd2, ST_DEC,  4'h0, 1'b0, 4'hF, 1'b0);
      // Contention: pointer after 2 -> 0, then 1, then 2.
      do_op(3'b011, 6'b111111, 12'h000, 1'b0, 2'd0, ST_CLR,  4'h0, 1'b0, 4'h0, 1'b0);
      do_op(3'b011, 6'b111111, 12'h000, 1'b0, 2'd1, ST_CLR,  4'h0, 1'b0, 4'h0, 1'b0);
      do_op(3'b101, 6'b100000, 12'h300, 1'b0, 2'd2, ST_PAR,  4'h3, 1'b0, 4'h3, 1'b0);
      // Increment while OP/LOAD_IN/REQ are scrambled during ISSUE.
      do_op(3'b001, 6'b000000, 12'h000, 1'b0, 2'd0, ST_INC,  4'h0, 1'b0, 4'h4, 1'b0);
      // Load abandoned by CLR during ISSUE.
      do_op(3'b010, 6'b001000, 12'h070, 1'b0, 2'd1, ST_PAR,  4'h7, 1'b0, 4'h0, 1'b1);
      // Pointer back at reset priority: 1 wins over 2.
      do_op(3'b110, 6'b000000, 12'h000, 1'b0, 2'd1, ST_INC,  4'h0, 1'b0, 4'h1, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
